// File: rtl/nas1_vid_capture.sv
// rtl/nas1_vid_capture.sv - NASCOM 1 composite video decoder to pixel coordinates
// Define NAS1_VID_CAPTURE_STATS_EN to add the last_line_clks/last_frame_lines outputs.
module nas1_vid_capture #(
    parameter int HSYNC_MIN    = 16,
    parameter int VSYNC_MIN    = 1024,
    parameter int H_START      = 10,
    parameter int H_PIXELS     = 384,
    parameter int V_START      = 4,
    parameter int V_LINES      = 256,
    parameter int LINE_TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_sync,
    input  logic        vid_data,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_data,
    output logic        frame_done,
    output logic        locked,
    output logic [7:0]  glitch_cnt
`ifdef NAS1_VID_CAPTURE_STATS_EN
    ,
    output logic [11:0] last_line_clks,
    output logic [9:0]  last_frame_lines
`endif
);

    localparam logic [11:0] HS_MIN_L = 12'(HSYNC_MIN);
    localparam logic [11:0] VS_MIN_L = 12'(VSYNC_MIN);
    localparam logic [11:0] TO_L     = 12'(LINE_TIMEOUT);
    localparam logic [9:0]  H_LO     = 10'(H_START);
    localparam logic [9:0]  H_HI     = 10'(H_START + H_PIXELS);
    localparam logic [9:0]  V_LO     = 10'(V_START);
    localparam logic [9:0]  V_HI     = 10'(V_START + V_LINES);

    typedef enum logic {SEARCH, FRAME} state_t;

    state_t      state, state_nxt;
    logic        sync_m, s_sync, sync_d, data_m, s_data;
    logic [11:0] lowcnt, idle_cnt;
    logic        phase, any_cap, frame_done_nxt;
    logic [9:0]  hcnt, vline;
    logic        sync_rise, sync_edge, ev_vs, ev_hs, ev_glitch, timeout, capture;

    // Sync path resets to the idle-high level so leaving reset is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_m <= 1'b1;
            s_sync <= 1'b1;
            sync_d <= 1'b1;
            data_m <= 1'b0;
            s_data <= 1'b0;
        end else begin
            sync_m <= vid_sync;
            s_sync <= sync_m;
            sync_d <= s_sync;
            data_m <= vid_data;
            s_data <= data_m;
        end
    end

    assign sync_rise = s_sync & ~sync_d;
    assign sync_edge = s_sync ^ sync_d;
    assign ev_vs     = sync_rise && (lowcnt >= VS_MIN_L);
    assign ev_hs     = sync_rise && (lowcnt >= HS_MIN_L) && (lowcnt < VS_MIN_L);
    assign ev_glitch = sync_rise && (lowcnt < HS_MIN_L);
    assign timeout   = (idle_cnt >= TO_L) && !sync_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lowcnt     <= 12'd0;
            idle_cnt   <= 12'd0;
            glitch_cnt <= 8'd0;
        end else begin
            if (s_sync)
                lowcnt <= 12'd0;
            else if (lowcnt != 12'hFFF)
                lowcnt <= lowcnt + 12'd1;
            if (sync_edge)
                idle_cnt <= 12'd0;
            else if (idle_cnt < TO_L)
                idle_cnt <= idle_cnt + 12'd1;
            if (ev_glitch && glitch_cnt != 8'hFF)
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            hcnt  <= 10'd0;
            vline <= 10'd0;
        end else begin
            if (ev_hs || ev_vs) begin
                phase <= 1'b0;
                hcnt  <= 10'd0;
            end else begin
                phase <= ~phase;
                if (phase && hcnt != 10'h3FF)
                    hcnt <= hcnt + 10'd1;
            end
            if (ev_vs)
                vline <= 10'd0;
            else if (ev_hs && vline != 10'h3FF)
                vline <= vline + 10'd1;
        end
    end

    // A sync event on the sampling clock wins over the sample
    assign capture = (state == FRAME) && phase && !ev_hs && !ev_vs && !timeout &&
                     (vline >= V_LO) && (vline < V_HI) && (hcnt >= H_LO) && (hcnt < H_HI);

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        case (state)
            SEARCH: if (ev_vs) state_nxt = FRAME;
            FRAME: begin
                if (ev_vs)
                    frame_done_nxt = any_cap;
                else if (timeout)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign locked = (state == FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            any_cap    <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= 10'd0;
            pix_y      <= 10'd0;
            pix_data   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
            pix_valid  <= capture;
            if (ev_vs)
                any_cap <= 1'b0;
            else if (capture)
                any_cap <= 1'b1;
            if (capture) begin
                pix_x    <= hcnt - H_LO;
                pix_y    <= vline - V_LO;
                pix_data <= s_data;
            end
        end
    end

`ifdef NAS1_VID_CAPTURE_STATS_EN
    logic [11:0] line_clks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_clks        <= 12'd0;
            last_line_clks   <= 12'd0;
            last_frame_lines <= 10'd0;
        end else begin
            if (ev_hs) begin
                line_clks      <= 12'd0;
                last_line_clks <= (line_clks == 12'hFFF) ? 12'hFFF : line_clks + 12'd1;
            end else if (line_clks != 12'hFFF) begin
                line_clks <= line_clks + 12'd1;
            end
            if (ev_vs)
                last_frame_lines <= vline;
        end
    end
`endif

endmodule
